// File: rtl/signal_spectrum.sv
// signal_spectrum: turns FFT bin pairs into per-band power values.
// Each pair of bins is squared and summed, adjacent bins in the lower half of
// the frame are accumulated into bands, and one saturated 16-bit power value
// is emitted per band. The redundant upper half of the frame is drained and
// dropped.
module signal_spectrum #(
  parameter int FRAME_BINS = 512,
  parameter int BAND_BINS  = 8,
  parameter int SHIFT      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic signed [15:0] transform1_real,
  input  logic signed [15:0] transform1_imag,
  input  logic               transform1_valid,
  output logic               transform1_rdy,
  input  logic signed [15:0] transform2_real,
  input  logic signed [15:0] transform2_imag,
  input  logic               transform2_valid,
  output logic               transform2_rdy,
  output logic [15:0]        power_data,
  output logic               power_valid,
  input  logic               power_rdy,
  output logic               power_last
);

  localparam int PAIRS          = FRAME_BINS / 2;
  localparam int PAIRS_PER_BAND = BAND_BINS / 2;
  localparam int BANDS          = FRAME_BINS / (2 * BAND_BINS);
  localparam int PAIR_W         = $clog2(PAIRS);
  localparam int BAND_W         = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int PSUM_W         = 33;
  localparam int ACC_W          = 37;

  typedef enum logic [2:0] {
    COLLECT,
    SQUARE,
    ACC,
    EMIT,
    DISCARD
  } state_t;

  state_t              state_q, state_d;
  logic                held1_q, held1_d;
  logic                held2_q, held2_d;
  logic signed [15:0]  re1_q, re1_d;
  logic signed [15:0]  im1_q, im1_d;
  logic signed [15:0]  re2_q, re2_d;
  logic signed [15:0]  im2_q, im2_d;
  logic [PSUM_W-1:0]   psum_q, psum_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PAIR_W-1:0]   pairCnt_q, pairCnt_d;
  logic [BAND_W-1:0]   bandCnt_q, bandCnt_d;
  logic [15:0]         powerData_q, powerData_d;
  logic                powerLast_q, powerLast_d;

  logic                acceptPhase;
  logic                take1;
  logic                take2;
  logic signed [31:0]  sqRe1, sqIm1, sqRe2, sqIm2;
  logic [PSUM_W-1:0]   psumNext;
  logic [ACC_W-1:0]    accSum;
  logic [ACC_W-1:0]    accShift;
  logic [15:0]         satData;
  logic                bandEnd;

  // Each stream may be accepted only while its own hold slot is empty.
  assign acceptPhase    = (state_q == COLLECT) || (state_q == DISCARD);
  assign transform1_rdy = acceptPhase && !held1_q;
  assign transform2_rdy = acceptPhase && !held2_q;
  assign take1          = transform1_valid && transform1_rdy;
  assign take2          = transform2_valid && transform2_rdy;

  // Squares of signed 16-bit values are non-negative and fit in 31 bits,
  // so the four-term sum fits in 33 unsigned bits without wrap.
  assign sqRe1    = re1_q * re1_q;
  assign sqIm1    = im1_q * im1_q;
  assign sqRe2    = re2_q * re2_q;
  assign sqIm2    = im2_q * im2_q;
  assign psumNext = {1'b0, sqRe1} + {1'b0, sqIm1} + {1'b0, sqRe2} + {1'b0, sqIm2};

  assign accSum   = acc_q + {{(ACC_W-PSUM_W){1'b0}}, psum_q};
  assign accShift = accSum >> SHIFT;
  assign satData  = (accShift > ACC_W'(16'hFFFF)) ? 16'hFFFF : accShift[15:0];
  assign bandEnd  = (pairCnt_q % PAIR_W'(PAIRS_PER_BAND)) == PAIR_W'(PAIRS_PER_BAND - 1);

  assign power_valid = (state_q == EMIT);
  assign power_data  = powerData_q;
  assign power_last  = powerLast_q;

  // Next-state logic: capture, square, accumulate, emit, drain upper half.
  always_comb begin
    state_d     = state_q;
    held1_d     = held1_q;
    held2_d     = held2_q;
    re1_d       = re1_q;
    im1_d       = im1_q;
    re2_d       = re2_q;
    im2_d       = im2_q;
    psum_d      = psum_q;
    acc_d       = acc_q;
    pairCnt_d   = pairCnt_q;
    bandCnt_d   = bandCnt_q;
    powerData_d = powerData_q;
    powerLast_d = powerLast_q;

    if (take1) begin
      held1_d = 1'b1;
      re1_d   = transform1_real;
      im1_d   = transform1_imag;
    end
    if (take2) begin
      held2_d = 1'b1;
      re2_d   = transform2_real;
      im2_d   = transform2_imag;
    end

    case (state_q)
      COLLECT: begin
        if (held1_q && held2_q) begin
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        psum_d  = psumNext;
        held1_d = 1'b0;
        held2_d = 1'b0;
        state_d = ACC;
      end
      ACC: begin
        acc_d     = accSum;
        pairCnt_d = pairCnt_q + PAIR_W'(1);
        if (bandEnd) begin
          powerData_d = satData;
          powerLast_d = (bandCnt_q == BAND_W'(BANDS - 1));
          state_d     = EMIT;
        end else begin
          state_d = COLLECT;
        end
      end
      EMIT: begin
        if (power_rdy) begin
          acc_d       = '0;
          bandCnt_d   = bandCnt_q + BAND_W'(1);
          powerData_d = '0;
          powerLast_d = 1'b0;
          state_d     = powerLast_q ? DISCARD : COLLECT;
        end
      end
      DISCARD: begin
        if (held1_q && held2_q) begin
          held1_d = 1'b0;
          held2_d = 1'b0;
          if (pairCnt_q == PAIR_W'(PAIRS - 1)) begin
            pairCnt_d = '0;
            bandCnt_d = '0;
            state_d   = COLLECT;
          end else begin
            pairCnt_d = pairCnt_q + PAIR_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    // A frame restart abandons everything in flight, including a pending band.
    if (init) begin
      state_d     = COLLECT;
      held1_d     = 1'b0;
      held2_d     = 1'b0;
      psum_d      = '0;
      acc_d       = '0;
      pairCnt_d   = '0;
      bandCnt_d   = '0;
      powerData_d = '0;
      powerLast_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      held1_q     <= 1'b0;
      held2_q     <= 1'b0;
      re1_q       <= '0;
      im1_q       <= '0;
      re2_q       <= '0;
      im2_q       <= '0;
      psum_q      <= '0;
      acc_q       <= '0;
      pairCnt_q   <= '0;
      bandCnt_q   <= '0;
      powerData_q <= '0;
      powerLast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      held1_q     <= held1_d;
      held2_q     <= held2_d;
      re1_q       <= re1_d;
      im1_q       <= im1_d;
      re2_q       <= re2_d;
      im2_q       <= im2_d;
      psum_q      <= psum_d;
      acc_q       <= acc_d;
      pairCnt_q   <= pairCnt_d;
      bandCnt_q   <= bandCnt_d;
      powerData_q <= powerData_d;
      powerLast_q <= powerLast_d;
    end
  end

endmodule
